// File: rtl/uv_span_walker_if.sv
// Command and sample-request bundle for the UV span walker.
// master = walker side, slave = command source / texture unit side.
interface uv_span_walker_if #(
    parameter int CORD_WIDTH = 16,
    parameter int X_BITS     = 10,
    parameter int Y_BITS     = 10
);
    logic                  i_cmd_valid;
    logic                  o_cmd_ready;
    logic [X_BITS-1:0]     i_x0;
    logic [Y_BITS-1:0]     i_y0;
    logic [X_BITS-1:0]     i_width;
    logic [Y_BITS-1:0]     i_height;
    logic [CORD_WIDTH-1:0] i_u0;
    logic [CORD_WIDTH-1:0] i_v0;
    logic [CORD_WIDTH-1:0] i_du_dx;
    logic [CORD_WIDTH-1:0] i_dv_dy;
    logic                  o_req_valid;
    logic                  i_req_ready;
    logic [CORD_WIDTH-1:0] o_u_coord;
    logic [CORD_WIDTH-1:0] o_v_coord;
    logic [X_BITS-1:0]     o_pix_x;
    logic [Y_BITS-1:0]     o_pix_y;
    logic                  o_last;
    logic                  o_busy;

    modport master (
        input  i_cmd_valid, i_x0, i_y0, i_width, i_height,
        input  i_u0, i_v0, i_du_dx, i_dv_dy, i_req_ready,
        output o_cmd_ready, o_req_valid, o_u_coord, o_v_coord,
        output o_pix_x, o_pix_y, o_last, o_busy
    );

    modport slave (
        output i_cmd_valid, i_x0, i_y0, i_width, i_height,
        output i_u0, i_v0, i_du_dx, i_dv_dy, i_req_ready,
        input  o_cmd_ready, o_req_valid, o_u_coord, o_v_coord,
        input  o_pix_x, o_pix_y, o_last, o_busy
    );
endinterface

// File: rtl/uv_span_walker.sv
// Walks an axis-aligned rectangle row-major, issuing one UV
// sample request per pixel with valid/ready backpressure.
module uv_span_walker #(
    parameter int CORD_WIDTH = 16,
    parameter int X_BITS     = 10,
    parameter int Y_BITS     = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    uv_span_walker_if.master bus
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WALK = 1'b1;

    localparam logic [X_BITS-1:0] X_ONE = X_BITS'(1);
    localparam logic [Y_BITS-1:0] Y_ONE = Y_BITS'(1);

    logic [0:0]            state;
    logic [X_BITS-1:0]     x0_q;
    logic [X_BITS-1:0]     width_q;
    logic [Y_BITS-1:0]     height_q;
    logic [CORD_WIDTH-1:0] u0_q;
    logic [CORD_WIDTH-1:0] du_q;
    logic [CORD_WIDTH-1:0] dv_q;
    logic [X_BITS-1:0]     col;
    logic [Y_BITS-1:0]     row;

    logic beat;
    logic row_end;
    logic last_row;
    logic next_is_last_row;

    assign bus.o_cmd_ready = (state == IDLE);

    assign beat     = bus.o_req_valid && bus.i_req_ready;
    assign row_end  = (col == width_q - X_ONE);
    assign last_row = (row == height_q - Y_ONE);
    assign next_is_last_row = (row + Y_ONE == height_q - Y_ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            x0_q            <= '0;
            width_q         <= '0;
            height_q        <= '0;
            u0_q            <= '0;
            du_q            <= '0;
            dv_q            <= '0;
            col             <= '0;
            row             <= '0;
            bus.o_req_valid <= 1'b0;
            bus.o_last      <= 1'b0;
            bus.o_busy      <= 1'b0;
            bus.o_u_coord   <= '0;
            bus.o_v_coord   <= '0;
            bus.o_pix_x     <= '0;
            bus.o_pix_y     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.i_cmd_valid) begin
                        x0_q     <= bus.i_x0;
                        width_q  <= bus.i_width;
                        height_q <= bus.i_height;
                        u0_q     <= bus.i_u0;
                        du_q     <= bus.i_du_dx;
                        dv_q     <= bus.i_dv_dy;
                        // empty rectangles are swallowed without a beat
                        if (bus.i_width != '0 && bus.i_height != '0) begin
                            state           <= WALK;
                            col             <= '0;
                            row             <= '0;
                            bus.o_pix_x     <= bus.i_x0;
                            bus.o_pix_y     <= bus.i_y0;
                            bus.o_u_coord   <= bus.i_u0;
                            bus.o_v_coord   <= bus.i_v0;
                            bus.o_req_valid <= 1'b1;
                            bus.o_busy      <= 1'b1;
                            bus.o_last      <= (bus.i_width == X_ONE) &&
                                               (bus.i_height == Y_ONE);
                        end
                    end
                end
                WALK: begin
                    if (beat) begin
                        if (bus.o_last) begin
                            state           <= IDLE;
                            bus.o_req_valid <= 1'b0;
                            bus.o_last      <= 1'b0;
                            bus.o_busy      <= 1'b0;
                        end else if (row_end) begin
                            col           <= '0;
                            row           <= row + Y_ONE;
                            bus.o_pix_x   <= x0_q;
                            bus.o_u_coord <= u0_q;
                            bus.o_pix_y   <= bus.o_pix_y + Y_ONE;
                            bus.o_v_coord <= bus.o_v_coord + dv_q;
                            bus.o_last    <= (width_q == X_ONE) &&
                                             next_is_last_row;
                        end else begin
                            col           <= col + X_ONE;
                            bus.o_pix_x   <= bus.o_pix_x + X_ONE;
                            bus.o_u_coord <= bus.o_u_coord + du_q;
                            bus.o_last    <= (col + X_ONE == width_q - X_ONE) &&
                                             last_row;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uv_span_walker.sv
// Directed bench for uv_span_walker: a rectangle-level model
// expands each command into its expected beat list.
module tb_uv_span_walker;
    localparam int CW = 16;
    localparam int XB = 10;
    localparam int YB = 10;

    typedef struct packed {
        logic [XB-1:0] x;
        logic [YB-1:0] y;
        logic [CW-1:0] u;
        logic [CW-1:0] v;
        logic          last;
    } beat_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   beats_seen = 0;
    int   ph = 0;
    bit   ready_mode = 1'b0;

    beat_t exp_q[$];
    beat_t cap[$];
    int    cap_cyc[$];

    uv_span_walker_if #(.CORD_WIDTH(CW), .X_BITS(XB), .Y_BITS(YB)) b ();

    uv_span_walker #(.CORD_WIDTH(CW), .X_BITS(XB), .Y_BITS(YB)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected beats follow directly from the rectangle definition.
    task automatic model_push(input logic [XB-1:0] x0, input logic [YB-1:0] y0,
                              input int w, input int h,
                              input logic [CW-1:0] u0, input logic [CW-1:0] v0,
                              input logic [CW-1:0] du, input logic [CW-1:0] dv);
        beat_t e;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                e.x    = x0 + XB'(c);
                e.y    = y0 + YB'(r);
                e.u    = u0 + CW'(c * int'(du));
                e.v    = v0 + CW'(r * int'(dv));
                e.last = (r == h - 1) && (c == w - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            ph++;
            b.i_req_ready = ready_mode ? (ph % 3 == 0) : 1'b1;
        end
    end

    beat_t held;
    bit    hold_pending = 1'b0;
    bit    post_last = 1'b0;

    always @(negedge clk) begin
        beat_t cur;
        beat_t e;
        cur = '{b.o_pix_x, b.o_pix_y, b.o_u_coord, b.o_v_coord, b.o_last};
        if (!rst_n) begin
            hold_pending = 1'b0;
            post_last = 1'b0;
        end else begin
            if (post_last) begin
                check("ready_after_last", 32'(b.o_cmd_ready), 32'd1);
                check("valid_after_last", 32'(b.o_req_valid), 32'd0);
                post_last = 1'b0;
            end
            if (hold_pending) begin
                check("hold_valid", 32'(b.o_req_valid), 32'd1);
                check("hold_data", 32'(cur == held), 32'd1);
                hold_pending = 1'b0;
            end
            if (exp_q.size() > 0 && !b.o_cmd_ready)
                check("valid_mid_walk", 32'(b.o_req_valid), 32'd1);
            if (b.o_req_valid && b.i_req_ready) begin
                beats_seen++;
                cap.push_back(cur);
                cap_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 32'(beats_seen), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_x", 32'(cur.x), 32'(e.x));
                    check("beat_y", 32'(cur.y), 32'(e.y));
                    check("beat_u", 32'(cur.u), 32'(e.u));
                    check("beat_v", 32'(cur.v), 32'(e.v));
                    check("beat_last", 32'(cur.last), 32'(e.last));
                end
                if (cur.last) post_last = 1'b1;
            end else if (b.o_req_valid) begin
                hold_pending = 1'b1;
                held = cur;
            end
        end
    end

    task automatic send_cmd(input logic [XB-1:0] x0, input logic [YB-1:0] y0,
                            input int w, input int h,
                            input logic [CW-1:0] u0, input logic [CW-1:0] v0,
                            input logic [CW-1:0] du, input logic [CW-1:0] dv);
        bit ok;
        ok = 1'b0;
        @(posedge clk);
        #1;
        b.i_cmd_valid = 1'b1;
        b.i_x0 = x0;
        b.i_y0 = y0;
        b.i_width = XB'(w);
        b.i_height = YB'(h);
        b.i_u0 = u0;
        b.i_v0 = v0;
        b.i_du_dx = du;
        b.i_dv_dy = dv;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (b.o_cmd_ready) begin
                model_push(x0, y0, w, h, u0, v0, du, dv);
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("cmd_accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        b.i_cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !b.o_busy && !b.o_req_valid) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("walk_timeout", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
    endtask

    task automatic clear_cap();
        cap.delete();
        cap_cyc.delete();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        bit ok;
        b.i_cmd_valid = 1'b0;
        b.i_req_ready = 1'b1;
        b.i_x0 = '0;
        b.i_y0 = '0;
        b.i_width = '0;
        b.i_height = '0;
        b.i_u0 = '0;
        b.i_v0 = '0;
        b.i_du_dx = '0;
        b.i_dv_dy = '0;
        #12;
        check("rst_cmd_ready", 32'(b.o_cmd_ready), 32'd1);
        check("rst_valid", 32'(b.o_req_valid), 32'd0);
        check("rst_last", 32'(b.o_last), 32'd0);
        check("rst_busy", 32'(b.o_busy), 32'd0);
        check("rst_uv", {b.o_u_coord, b.o_v_coord}, 32'd0);
        check("rst_xy", 32'({b.o_pix_x, b.o_pix_y}), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(b.o_cmd_ready), 32'd1);

        clear_cap();
        send_cmd(10'd5, 10'd7, 3, 2, 16'h0000, 16'h8000, 16'h1000, 16'h2000);
        wait_idle();
        check("basic_count", 32'(cap.size()), 32'd6);
        if (cap.size() == 6) begin
            check("basic_consecutive", 32'(cap_cyc[5] - cap_cyc[0]), 32'd5);
            check("basic_b2_u", 32'(cap[2].u), 32'h2000);
            check("basic_b3_xy", 32'({cap[3].x, cap[3].y}), 32'({10'd5, 10'd8}));
            check("basic_b3_uv", {cap[3].u, cap[3].v}, 32'h0000_A000);
            check("basic_b4_last", 32'(cap[4].last), 32'd0);
            check("basic_b5_last", 32'(cap[5].last), 32'd1);
        end

        clear_cap();
        ready_mode = 1'b1;
        send_cmd(10'd5, 10'd7, 3, 2, 16'h0000, 16'h8000, 16'h1000, 16'h2000);
        wait_idle();
        ready_mode = 1'b0;
        check("bp_count", 32'(cap.size()), 32'd6);
        if (cap.size() == 6) begin
            check("bp_b4", {6'd0, cap[4].x, cap[4].u}, {6'd0, 10'd6, 16'h1000});
            check("bp_stretched", 32'(cap_cyc[5] - cap_cyc[0] > 5), 32'd1);
        end

        clear_cap();
        send_cmd(10'd1, 10'd1, 0, 4, 16'h1111, 16'h2222, 16'h1, 16'h1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("zero_w_valid", 32'(b.o_req_valid), 32'd0);
            check("zero_w_ready", 32'(b.o_cmd_ready), 32'd1);
        end
        send_cmd(10'd1, 10'd1, 4, 0, 16'h1111, 16'h2222, 16'h1, 16'h1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("zero_h_valid", 32'(b.o_req_valid), 32'd0);
            check("zero_h_ready", 32'(b.o_cmd_ready), 32'd1);
        end
        check("zero_no_beats", 32'(cap.size()), 32'd0);

        clear_cap();
        send_cmd(10'd1023, 10'd0, 2, 1, 16'hF000, 16'h0000, 16'h2000, 16'h0000);
        wait_idle();
        check("wrap_count", 32'(cap.size()), 32'd2);
        if (cap.size() == 2) begin
            check("wrap_b0", {6'd0, cap[0].x, cap[0].u}, {6'd0, 10'd1023, 16'hF000});
            check("wrap_b1", {6'd0, cap[1].x, cap[1].u}, {6'd0, 10'd0, 16'h1000});
            check("wrap_last", 32'({cap[0].last, cap[1].last}), 32'b01);
        end

        clear_cap();
        send_cmd(10'd5, 10'd7, 3, 2, 16'h0000, 16'h8000, 16'h1000, 16'h2000);
        @(posedge clk);
        #1;
        b.i_cmd_valid = 1'b1;
        b.i_x0 = 10'd100;
        b.i_width = 10'd1;
        b.i_height = 10'd1;
        b.i_u0 = 16'h5555;
        @(negedge clk);
        check("busy_cmd_ready", 32'(b.o_cmd_ready), 32'd0);
        @(posedge clk);
        #1;
        b.i_cmd_valid = 1'b0;
        wait_idle();
        check("busy_cmd_count", 32'(cap.size()), 32'd6);

        clear_cap();
        base = beats_seen;
        send_cmd(10'd5, 10'd7, 3, 2, 16'h0000, 16'h8000, 16'h1000, 16'h2000);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (beats_seen == base + 2) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check("rst_wait_timeout", 32'(beats_seen - base), 32'd2);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("mid_rst_valid", 32'(b.o_req_valid), 32'd0);
        check("mid_rst_last_busy", 32'({b.o_last, b.o_busy}), 32'd0);
        check("mid_rst_coords",
              32'({b.o_u_coord, b.o_v_coord} | 32'({b.o_pix_x, b.o_pix_y})), 32'd0);
        check("mid_rst_ready", 32'(b.o_cmd_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        base = beats_seen;
        repeat (3) begin
            @(negedge clk);
            check("rel_ready", 32'(b.o_cmd_ready), 32'd1);
            check("rel_valid", 32'(b.o_req_valid), 32'd0);
        end
        check("rel_no_beats", 32'(beats_seen - base), 32'd0);
        clear_cap();
        send_cmd(10'd9, 10'd3, 1, 1, 16'h1234, 16'h5678, 16'h0100, 16'h0100);
        wait_idle();
        check("one_count", 32'(cap.size()), 32'd1);
        if (cap.size() == 1) begin
            check("one_last", 32'(cap[0].last), 32'd1);
            check("one_uv", {cap[0].u, cap[0].v}, 32'h1234_5678);
            check("one_xy", 32'({cap[0].x, cap[0].y}), 32'({10'd9, 10'd3}));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
